// File: rtl/jogo_memoria_param.sv
// Memory game: the player repeats a growing one-hot sequence (ROM or player-extended) against a per-play timeout.
// One play is evaluated 3 cycles after its button edge; there is no backpressure, and presses outside the wait states are ignored.
module jogo_memoria_param #(
  parameter int N_BOTOES     = 4,
  parameter int PROFUNDIDADE = 16,
  parameter int TIMEOUT      = 3000
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            jogar,
  input  logic                            modo,
  input  logic [N_BOTOES-1:0]             botoes,
  output logic [N_BOTOES-1:0]             leds,
  output logic                            pronto,
  output logic                            ganhou,
  output logic                            perdeu,
  output logic [3:0]                      db_estado,
  output logic [$clog2(PROFUNDIDADE)-1:0] db_rodada,
  output logic [$clog2(PROFUNDIDADE)-1:0] db_jogada,
  output logic                            db_timeout
);

  localparam int RW = $clog2(PROFUNDIDADE);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    ESPERA_JOGADA  = 4'h2,
    REGISTRA       = 4'h3,
    COMPARA        = 4'h4,
    PROXIMA_JOGADA = 4'h5,
    FIM_RODADA     = 4'h6,
    ESPERA_NOVA    = 4'h7,
    GRAVA          = 4'h8,
    PROXIMA_RODADA = 4'h9,
    GANHOU         = 4'hA,
    PERDEU         = 4'hE
  } estado_t;

  estado_t             estado;
  logic [RW-1:0]       rodada;
  logic [RW-1:0]       jogada;
  logic [TW-1:0]       tempo;
  logic                botoes_or_q;
  logic                modo_q;
  logic [N_BOTOES-1:0] memoria [PROFUNDIDADE];

  logic                jogada_det;
  logic                espera;
  logic                estourou;
  logic [N_BOTOES-1:0] esperado;

  function automatic logic [N_BOTOES-1:0] rom(input logic [RW-1:0] k);
    logic [N_BOTOES-1:0] v;
    v = '0;
    for (int i = 0; i < N_BOTOES; i++) v[i] = ((int'(k) % N_BOTOES) == i);
    return v;
  endfunction

  function automatic logic one_hot(input logic [N_BOTOES-1:0] x);
    return (x != '0) && ((x & (x - 1'b1)) == '0);
  endfunction

  // A play is the rising edge of "any button pressed"; holding keys yields one play.
  assign jogada_det = (|botoes) & ~botoes_or_q;
  assign espera     = (estado == ESPERA_JOGADA) || (estado == ESPERA_NOVA);
  assign estourou   = espera && !jogada_det && (tempo == TW'(TIMEOUT - 1));
  assign esperado   = modo_q ? memoria[jogada] : rom(jogada);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado      <= INICIAL;
      rodada      <= '0;
      jogada      <= '0;
      leds        <= '0;
      tempo       <= '0;
      botoes_or_q <= 1'b0;
      modo_q      <= 1'b0;
    end else begin
      botoes_or_q <= |botoes;
      // Every entry into a wait state comes from a non-wait state, so this clears on entry.
      tempo       <= espera ? tempo + 1'b1 : '0;
      case (estado)
        INICIAL: if (jogar) estado <= PREPARACAO;
        PREPARACAO: begin
          rodada <= '0;
          jogada <= '0;
          leds   <= '0;
          modo_q <= modo;
          estado <= ESPERA_JOGADA;
        end
        ESPERA_JOGADA: begin
          if (jogada_det)    estado <= REGISTRA;
          else if (estourou) estado <= PERDEU;
        end
        REGISTRA: begin
          leds   <= botoes;
          estado <= COMPARA;
        end
        COMPARA: begin
          if (!(one_hot(leds) && leds == esperado)) estado <= PERDEU;
          else if (jogada < rodada)                 estado <= PROXIMA_JOGADA;
          else                                      estado <= FIM_RODADA;
        end
        PROXIMA_JOGADA: begin
          jogada <= jogada + 1'b1;
          estado <= ESPERA_JOGADA;
        end
        FIM_RODADA: begin
          if (rodada == RW'(PROFUNDIDADE - 1)) estado <= GANHOU;
          else if (modo_q)                     estado <= ESPERA_NOVA;
          else                                 estado <= PROXIMA_RODADA;
        end
        ESPERA_NOVA: begin
          if (jogada_det) begin
            leds   <= botoes;
            estado <= one_hot(botoes) ? GRAVA : PERDEU;
          end else if (estourou) begin
            estado <= PERDEU;
          end
        end
        GRAVA: estado <= PROXIMA_RODADA;
        PROXIMA_RODADA: begin
          rodada <= rodada + 1'b1;
          jogada <= '0;
          estado <= ESPERA_JOGADA;
        end
        GANHOU, PERDEU: if (jogar) estado <= PREPARACAO;
        default: estado <= INICIAL;
      endcase
    end
  end

  // Sequence storage carries no reset; it is reloaded at the start of every game.
  always_ff @(posedge clock) begin
    if (estado == PREPARACAO && modo) memoria[0] <= rom('0);
    else if (estado == GRAVA)         memoria[rodada + 1'b1] <= leds;
  end

  assign ganhou     = (estado == GANHOU);
  assign perdeu     = (estado == PERDEU);
  assign pronto     = ganhou | perdeu;
  assign db_estado  = estado;
  assign db_rodada  = rodada;
  assign db_jogada  = jogada;
  assign db_timeout = estourou;

endmodule

// File: doc/jogo_memoria_param.md
JOGO_MEMORIA_PARAM -- requirements
Module: jogo_memoria_param

Interface
REQ-001 Parameter N_BOTOES, default 4, number of buttons/LEDs (2..8).
REQ-002 Parameter PROFUNDIDADE, default 16, maximum rounds and sequence memory depth (power of 2, 2..64).
REQ-003 Parameter TIMEOUT, default 3000, clock cycles allowed per play before loss.
REQ-004 clock  in  1  system clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high; forces the reset state of REQ-031 immediately.
REQ-006 jogar  in  1  level; starts a game from inicial, ganhou or perdeu.
REQ-007 modo  in  1  sampled at game start; 0 = fixed ROM sequence, 1 = player-extended sequence.
REQ-008 botoes  in  N_BOTOES  raw buttons, level, already synchronised.
REQ-009 leds  out  N_BOTOES  last registered play, one-hot.
REQ-010 pronto  out  1  high in ganhou and perdeu.
REQ-011 ganhou  out  1  high in ganhou state.
REQ-012 perdeu  out  1  high in perdeu state.
REQ-013 db_estado  out  4  state code per REQ-017.
REQ-014 db_rodada  out  log2(PROFUNDIDADE)  current round index (0-based).
REQ-015 db_jogada  out  log2(PROFUNDIDADE)  play index within round.
REQ-016 db_timeout  out  1  one-cycle pulse when timeout fires.

Function
REQ-017 States/codes: inicial 0, preparacao 1, espera_jogada 2, registra 3, compara 4, proxima_jogada 5, fim_rodada 6, espera_nova 7, grava 8, proxima_rodada 9, ganhou A, perdeu E.
REQ-018 inicial -> preparacao when jogar=1; ganhou/perdeu -> preparacao when jogar=1, else hold.
REQ-019 preparacao (1 cycle): clear rodada, jogada, leds, timeout counter; latch modo; in modo 1 load memory[0] from ROM entry 0.
REQ-020 ROM entry k = one-hot with bit (k mod N_BOTOES) set.
REQ-021 Play detection: rising edge of OR-reduce(botoes) (registered previous OR); holding buttons produces one play only.
REQ-022 espera_jogada -> registra on detected play; registra captures botoes into leds register (1 cycle), then compara.
REQ-023 compara: match iff captured value equals expected (ROM in modo 0, sequence memory in modo 1); a non-one-hot capture is a mismatch.
REQ-024 Mismatch -> perdeu; match and jogada<rodada -> proxima_jogada (jogada+1) -> espera_jogada; match and jogada=rodada -> fim_rodada.
REQ-025 fim_rodada: rodada=PROFUNDIDADE-1 -> ganhou; else modo 0 -> proxima_rodada; modo 1 -> espera_nova.
REQ-026 espera_nova: next detected one-hot play -> grava, writes it to memory[rodada+1] (1 cycle) -> proxima_rodada; non-one-hot play -> perdeu.
REQ-027 proxima_rodada: rodada+1, jogada=0, -> espera_jogada.
REQ-028 Timeout counter clears on entry to espera_jogada and espera_nova, increments each cycle there; at TIMEOUT-1 without a play -> perdeu with db_timeout pulse that cycle.
REQ-029 Play and timeout in the same cycle: play wins.
REQ-030 Counters never wrap: rodada saturates via ganhou transition; jogada bounded by rodada.

Reset
REQ-031 On reset: state inicial, leds=0, pronto=ganhou=perdeu=0, db_rodada=db_jogada=0, db_timeout=0, edge register=0, timeout counter=0; memory contents undefined and reloaded per REQ-019.
REQ-032 Reset mid-game abandons the game; the next game requires jogar.

Verification
REQ-033 Default params, modo 0, jogar 5 cycles, then rounds 0..15 played with ROM values (0001,0010,0100,1000,...), 10-cycle press/10-cycle gap -> ganhou=1, pronto=1, db_estado=A.
REQ-034 Modo 0, round 2 second play 0100 instead of 0010 -> perdeu=1, db_estado=E, db_rodada=2, db_jogada=1.
REQ-035 After round 0 correct, no input 3000 cycles -> db_timeout pulse, perdeu=1 at cycle 3000.
REQ-036 Modo 1: play 0001, add 1000, play 0001,1000, add 0100 -> db_rodada=2, memory[2]=0100; then 0001,1000,0010 -> perdeu.
REQ-037 botoes=0011 in espera_jogada -> perdeu; reset asserted in espera_jogada -> outputs per REQ-031 asynchronously, db_estado=0.
REQ-038 N_BOTOES=6, PROFUNDIDADE=4, TIMEOUT=50: full win with ROM values 000001..001000, and 50-cycle idle -> timeout loss.
